// File: rtl/iob_vexriscv_ibus_axi2iob_pkg.sv
// Shared constants, FSM encoding and AR legality check for the iBus AXI-to-IOb bridge.
package iob_vexriscv_ibus_axi2iob_pkg;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [2:0] AXI_SIZE_4B     = 3'd2;
    localparam int         RSP_DEPTH       = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_ERR   = 2'd2
    } state_t;

    // Only full-word FIXED/INCR bursts map onto single-word IOb reads.
    function automatic logic ar_legal(input logic [2:0] size, input logic [1:0] burst);
        return (size == AXI_SIZE_4B) && ((burst == AXI_BURST_FIXED) || (burst == AXI_BURST_INCR));
    endfunction

endpackage

// File: rtl/iob_ibus_rsp_buf.sv
// Two-entry register FIFO holding IOb read data until the R channel takes it.
module iob_ibus_rsp_buf #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              arst_n_i,
    input  logic              cke_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              pop_i,
    output logic [DATA_W-1:0] data_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [1:0]        level_o
);

    logic [1:0][DATA_W-1:0] mem_q;
    logic                   wr_ptr_q;
    logic                   rd_ptr_q;
    logic [1:0]             level_q;

    // Caller guarantees no push on full without a pop and no pop on empty.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            mem_q    <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            level_q  <= 2'd0;
        end else if (cke_i) begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_i) rd_ptr_q <= ~rd_ptr_q;
            case ({push_i, pop_i})
                2'b10:   level_q <= level_q + 2'd1;
                2'b01:   level_q <= level_q - 2'd1;
                default: ;
            endcase
        end
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = (level_q == 2'd2);
    assign empty_o = (level_q == 2'd0);
    assign level_o = level_q;

endmodule

// File: rtl/iob_vexriscv_ibus_axi2iob.sv
// AXI4 read-only slave turning VexRiscv iBus bursts into single-word IOb reads,
// with at most two reads in flight or buffered so R backpressure never loses data.
module iob_vexriscv_ibus_axi2iob
    import iob_vexriscv_ibus_axi2iob_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int AXI_ID_W  = 1,
    parameter int AXI_LEN_W = 8
) (
    input  logic                  clk_i,
    input  logic                  arst_n_i,
    input  logic                  cke_i,
    input  logic                  axi_arvalid_i,
    output logic                  axi_arready_o,
    input  logic [ADDR_W-1:0]     axi_araddr_i,
    input  logic [AXI_ID_W-1:0]   axi_arid_i,
    input  logic [AXI_LEN_W-1:0]  axi_arlen_i,
    input  logic [2:0]            axi_arsize_i,
    input  logic [1:0]            axi_arburst_i,
    output logic                  axi_rvalid_o,
    input  logic                  axi_rready_i,
    output logic [DATA_W-1:0]     axi_rdata_o,
    output logic [AXI_ID_W-1:0]   axi_rid_o,
    output logic [1:0]            axi_rresp_o,
    output logic                  axi_rlast_o,
    output logic                  iob_avalid_o,
    output logic [ADDR_W-1:0]     iob_addr_o,
    output logic [DATA_W-1:0]     iob_wdata_o,
    output logic [DATA_W/8-1:0]   iob_wstrb_o,
    input  logic                  iob_ready_i,
    input  logic                  iob_rvalid_i,
    input  logic [DATA_W-1:0]     iob_rdata_i
);

    localparam logic [AXI_LEN_W:0] CNT_ONE = (AXI_LEN_W+1)'(1);

    state_t                state_q, state_d;
    logic                  rst_done_q;
    logic [AXI_ID_W-1:0]   id_q;
    logic [ADDR_W-1:0]     addr_q;
    logic [AXI_LEN_W:0]    len_q;
    logic [AXI_LEN_W:0]    issued_q;
    logic [AXI_LEN_W:0]    delivered_q;
    logic                  incr_q;
    logic [1:0]            outst_q;

    logic                  ar_hs, iob_hs, r_hs, last_beat;
    logic                  rsp_take, rsp_push, buf_pop, credit_ok;
    logic                  buf_full, buf_empty;
    logic [1:0]            buf_level;
    logic [2:0]            occupancy;
    logic [DATA_W-1:0]     buf_data;

    assign ar_hs     = axi_arvalid_i & axi_arready_o;
    assign iob_hs    = iob_avalid_o & iob_ready_i;
    assign r_hs      = axi_rvalid_o & axi_rready_i & cke_i;
    assign last_beat = (delivered_q == len_q);
    assign buf_pop   = r_hs & (state_q == ST_BURST);
    // Read data with nothing outstanding is a memory protocol error; drop it.
    assign rsp_take  = cke_i & iob_rvalid_i & (outst_q != 2'd0);
    assign rsp_push  = rsp_take & (~buf_full | buf_pop);

    // A slot freed by this cycle's pop is reusable now, giving one beat per cycle.
    assign occupancy = {1'b0, buf_level} + {1'b0, outst_q};
    assign credit_ok = occupancy < (3'(RSP_DEPTH) + {2'b00, buf_pop});

    iob_ibus_rsp_buf #(.DATA_W(DATA_W)) u_rsp_buf (
        .clk_i    (clk_i),
        .arst_n_i (arst_n_i),
        .cke_i    (cke_i),
        .push_i   (rsp_push),
        .data_i   (iob_rdata_i),
        .pop_i    (buf_pop),
        .data_o   (buf_data),
        .full_o   (buf_full),
        .empty_o  (buf_empty),
        .level_o  (buf_level)
    );

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q     <= ST_IDLE;
            rst_done_q  <= 1'b0;
            id_q        <= '0;
            addr_q      <= '0;
            len_q       <= '0;
            incr_q      <= 1'b0;
            issued_q    <= '0;
            delivered_q <= '0;
            outst_q     <= 2'd0;
        end else if (cke_i) begin
            state_q    <= state_d;
            rst_done_q <= 1'b1;
            if (ar_hs) begin
                id_q        <= axi_arid_i;
                addr_q      <= {axi_araddr_i[ADDR_W-1:2], 2'b00};
                len_q       <= {1'b0, axi_arlen_i};
                incr_q      <= (axi_arburst_i == AXI_BURST_INCR);
                issued_q    <= '0;
                delivered_q <= '0;
            end else begin
                if (iob_hs) begin
                    issued_q <= issued_q + CNT_ONE;
                    if (incr_q) addr_q <= addr_q + ADDR_W'(4);
                end
                if (r_hs) delivered_q <= delivered_q + CNT_ONE;
            end
            case ({iob_hs, rsp_take})
                2'b10:   outst_q <= outst_q + 2'd1;
                2'b01:   outst_q <= outst_q - 2'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (ar_hs) state_d = ar_legal(axi_arsize_i, axi_arburst_i) ? ST_BURST : ST_ERR;
            ST_BURST,
            ST_ERR:   if (r_hs && last_beat) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        axi_arready_o = cke_i & rst_done_q & (state_q == ST_IDLE);
        axi_rvalid_o  = 1'b0;
        axi_rdata_o   = '0;
        axi_rresp_o   = AXI_RESP_OKAY;
        case (state_q)
            ST_BURST: begin
                axi_rvalid_o = ~buf_empty;
                axi_rdata_o  = buf_empty ? '0 : buf_data;
            end
            ST_ERR: begin
                axi_rvalid_o = 1'b1;
                axi_rresp_o  = AXI_RESP_SLVERR;
            end
            default: ;
        endcase
        axi_rlast_o = axi_rvalid_o & last_beat;
    end

    assign iob_avalid_o = cke_i & (state_q == ST_BURST) & (issued_q <= len_q) & credit_ok;
    assign iob_addr_o   = addr_q;
    assign iob_wdata_o  = '0;
    assign iob_wstrb_o  = '0;
    assign axi_rid_o    = id_q;

endmodule

// File: tb/tb_iob_vexriscv_ibus_axi2iob.sv
// Randomized scoreboard bench: expected beats and IOb addresses are queued when an AR
// is issued; an IOb memory model and an R-channel monitor check them independently.
module tb_iob_vexriscv_ibus_axi2iob;

    logic        clk = 1'b0;
    logic        arst_n = 1'b0;
    logic        cke = 1'b1;
    logic        arvalid = 1'b0;
    logic [31:0] araddr = '0;
    logic        arid = 1'b0;
    logic [7:0]  arlen = '0;
    logic [2:0]  arsize = '0;
    logic [1:0]  arburst = '0;
    logic        rready = 1'b0;
    logic        iob_ready = 1'b0;
    logic        iob_rvalid = 1'b0;
    logic [31:0] iob_rdata = '0;

    logic        arready, rvalid, rid, rlast, iob_avalid;
    logic [31:0] rdata, iob_addr, iob_wdata;
    logic [1:0]  rresp;
    logic [3:0]  iob_wstrb;

    iob_vexriscv_ibus_axi2iob dut (
        .clk_i         (clk),
        .arst_n_i      (arst_n),
        .cke_i         (cke),
        .axi_arvalid_i (arvalid),
        .axi_arready_o (arready),
        .axi_araddr_i  (araddr),
        .axi_arid_i    (arid),
        .axi_arlen_i   (arlen),
        .axi_arsize_i  (arsize),
        .axi_arburst_i (arburst),
        .axi_rvalid_o  (rvalid),
        .axi_rready_i  (rready),
        .axi_rdata_o   (rdata),
        .axi_rid_o     (rid),
        .axi_rresp_o   (rresp),
        .axi_rlast_o   (rlast),
        .iob_avalid_o  (iob_avalid),
        .iob_addr_o    (iob_addr),
        .iob_wdata_o   (iob_wdata),
        .iob_wstrb_o   (iob_wstrb),
        .iob_ready_i   (iob_ready),
        .iob_rvalid_i  (iob_rvalid),
        .iob_rdata_i   (iob_rdata)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic [1:0] resp; logic last; logic id; } beat_t;
    typedef struct { logic [31:0] data; int due; logic stale; } pend_t;

    beat_t       expq[$];
    logic [31:0] addrq[$];
    pend_t       pendq[$];

    int checks = 0, errors = 0, cyc = 0, live_outst = 0, last_due = 0;
    int lat_min = 1, lat_max = 1, ready_pct = 100, rready_mode = 0;
    bit cke_rand = 1'b0, spur_en = 1'b0;
    int t_first = -1, t_last = -1, t_ar = -1;

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_2468;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", nm, act, exp);
        end
    endtask

    // Reference model: a burst is a list of word addresses or, if illegal, zero-data error beats.
    task automatic push_expect(input logic [31:0] a, input int len, input logic [1:0] burst,
                               input logic [2:0] size, input logic id);
        bit          legal;
        logic [31:0] base, wa;
        beat_t       b;
        legal = (size == 3'd2) && (burst == 2'b00 || burst == 2'b01);
        base  = {a[31:2], 2'b00};
        for (int i = 0; i <= len; i++) begin
            wa     = (burst == 2'b01) ? base + 32'(4 * i) : base;
            b.last = (i == len);
            b.id   = id;
            if (legal) begin
                addrq.push_back(wa);
                b.data = memfn(wa);
                b.resp = 2'b00;
            end else begin
                b.data = '0;
                b.resp = 2'b10;
            end
            expq.push_back(b);
        end
    endtask

    task automatic do_ar(input logic [31:0] a, input int len, input logic [1:0] burst,
                         input logic [2:0] size, input logic id);
        int n;
        @(negedge clk);
        arvalid = 1'b1; araddr = a; arlen = 8'(len); arburst = burst; arsize = size; arid = id;
        n = 0;
        forever begin
            #1;
            if (arready) break;
            n++;
            if (n > 3000) begin
                checks++; errors++;
                $display("FAIL ar_timeout addr %0h not accepted", a);
                break;
            end
            @(negedge clk);
        end
        t_ar = cyc;
        if (n <= 3000) push_expect(a, len, burst, size, id);
        @(negedge clk);
        arvalid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((expq.size() > 0 || addrq.size() > 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 5000) begin
            errors++;
            $display("FAIL drain_timeout beats_left %0d addrs_left %0d want 0", expq.size(), addrq.size());
            expq.delete();
            addrq.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // IOb memory model plus R-channel backpressure and clock-enable generator.
    initial begin : responder
        pend_t p;
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            cyc++;
            cke        = cke_rand ? ($urandom_range(0, 4) != 0) : 1'b1;
            iob_rvalid = 1'b0;
            iob_rdata  = $urandom;
            if (cke && pendq.size() > 0 && pendq[0].due <= cyc) begin
                p = pendq.pop_front();
                iob_rvalid = 1'b1;
                iob_rdata  = p.data;
                if (!p.stale) live_outst--;
            end else if (spur_en && cke && pendq.size() == 0 && live_outst == 0 && $urandom_range(0, 9) == 0) begin
                iob_rvalid = 1'b1;
            end
            iob_ready = ($urandom_range(0, 99) < ready_pct);
            case (rready_mode)
                0:       rready = 1'b1;
                1:       rready = (cyc % 4 == 0) || (cyc % 4 == 3);
                default: rready = ($urandom_range(0, 2) != 0);
            endcase
            #1;
            if (!cke) begin
                chk("cke_low_ready_avalid", {62'd0, arready, iob_avalid}, 64'd0);
            end else if (arst_n && iob_avalid && iob_ready) begin
                checks++;
                if (addrq.size() == 0) begin
                    errors++;
                    $display("FAIL iob_unexpected_req addr %0h want none", iob_addr);
                end else begin
                    ea = addrq.pop_front();
                    if (iob_addr !== ea) begin
                        errors++;
                        $display("FAIL iob_addr got %0h want %0h", iob_addr, ea);
                    end
                end
                p.data  = memfn(iob_addr);
                p.due   = cyc + int'($urandom_range(lat_max, lat_min));
                if (p.due < last_due) p.due = last_due;
                last_due = p.due;
                p.stale = 1'b0;
                pendq.push_back(p);
                live_outst++;
                checks++;
                if (live_outst > 2) begin
                    errors++;
                    $display("FAIL outstanding got %0d want <=2", live_outst);
                end
            end
        end
    end

    initial begin : monitor
        beat_t       e;
        logic        hold, nb, hl;
        logic [31:0] hd;
        hold = 1'b0; nb = 1'b1; hl = 1'b0; hd = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!arst_n) begin
                hold = 1'b0;
                nb   = 1'b1;
                continue;
            end
            if (hold) begin
                checks++;
                if (!rvalid || rdata !== hd || rlast !== hl) begin
                    errors++;
                    $display("FAIL r_hold got v%0b d%0h l%0b want v1 d%0h l%0b", rvalid, rdata, rlast, hd, hl);
                end
            end
            if (rvalid && rready && cke) begin
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL r_unexpected_beat data %0h resp %0h want none", rdata, rresp);
                end else begin
                    e = expq.pop_front();
                    if ({rdata, rresp, rlast, rid} !== {e.data, e.resp, e.last, e.id}) begin
                        errors++;
                        $display("FAIL r_beat got d%0h r%0h l%0b id%0b want d%0h r%0h l%0b id%0b",
                                 rdata, rresp, rlast, rid, e.data, e.resp, e.last, e.id);
                    end
                    if (nb) t_first = cyc;
                    if (e.last) t_last = cyc;
                    nb = e.last;
                end
            end
            hold = rvalid && !(rready && cke);
            hd   = rdata;
            hl   = rlast;
        end
    end

    initial begin : watchdog
        #500000;
        errors++;
        $display("FAIL watchdog sim did not finish");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : main
        int          ta1, ta2, n;
        logic [31:0] ra;
        int          rl;
        logic [1:0]  rb;
        logic [2:0]  rs;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_arready", 64'(arready), 64'd0);
        chk("rst_rvalid_avalid_rlast", {61'd0, rvalid, iob_avalid, rlast}, 64'd0);
        @(negedge clk);
        #3 arst_n = 1'b1;
        @(negedge clk);
        #1 chk("arready_after_release", 64'(arready), 64'd1);

        // Zero-wait INCR burst, then FIXED burst queued right behind it.
        do_ar(32'h0000_0100, 7, 2'b01, 3'd2, 1'b0);
        ta1 = t_ar;
        do_ar(32'h0000_0040, 3, 2'b00, 3'd2, 1'b1);
        ta2 = t_ar;
        chk("first_beat_latency", 64'(t_first - ta1), 64'd3);
        chk("last_beat_latency", 64'(t_last - ta1), 64'd10);
        chk("next_ar_latency", 64'(ta2 - ta1), 64'd11);
        wait_drain();

        // Slow memory with 1001 rready pattern.
        lat_min = 3; lat_max = 3; rready_mode = 1;
        do_ar(32'h0000_0200, 3, 2'b01, 3'd2, 1'b0);
        wait_drain();

        // Illegal bursts: WRAP, narrow size, reserved burst type.
        lat_min = 1; lat_max = 1; rready_mode = 2;
        do_ar(32'h0000_0300, 3, 2'b10, 3'd2, 1'b0);
        do_ar(32'h0000_0300, 3, 2'b01, 3'd1, 1'b1);
        do_ar(32'h0000_0000, 1, 2'b11, 3'd2, 1'b0);
        wait_drain();

        // Maximum length burst wrapping the address space.
        lat_max = 4; ready_pct = 70;
        do_ar(32'hFFFF_FFF0, 255, 2'b01, 3'd2, 1'b1);
        wait_drain();

        spur_en = 1'b1;
        for (int k = 0; k < 25; k++) begin
            ra = $urandom;
            rl = $urandom_range(0, 12);
            rb = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
            rs = ($urandom_range(0, 9) < 9) ? 3'd2 : 3'($urandom_range(0, 7));
            lat_max     = $urandom_range(1, 4);
            ready_pct   = $urandom_range(40, 100);
            rready_mode = $urandom_range(0, 2);
            cke_rand    = ($urandom_range(0, 3) == 0);
            do_ar(ra, rl, rb, rs, 1'($urandom_range(0, 1)));
        end
        wait_drain();
        cke_rand = 1'b0;
        spur_en  = 1'b0;

        // Reset in the middle of a burst while a beat is presented.
        lat_min = 2; lat_max = 2; ready_pct = 100; rready_mode = 2;
        do_ar(32'h0000_0500, 15, 2'b01, 3'd2, 1'b0);
        n = 0;
        forever begin
            @(negedge clk);
            #1;
            if (rvalid || n > 200) break;
            n++;
        end
        chk("rvalid_before_reset", 64'(rvalid), 64'd1);
        #2 arst_n = 1'b0;
        expq.delete();
        addrq.delete();
        foreach (pendq[i]) pendq[i].stale = 1'b1;
        live_outst = 0;
        #1;
        chk("midrst_outputs", {58'd0, rvalid, arready, iob_avalid, rlast, rid, 1'b0}, 64'd0);
        chk("midrst_rdata_addr", {rdata, iob_addr}, 64'd0);
        @(negedge clk);
        #3 arst_n = 1'b1;
        @(negedge clk);
        #1 chk("arready_after_midrst", 64'(arready), 64'd1);
        repeat (8) @(negedge clk);
        rready_mode = 0;
        do_ar(32'h0000_0600, 0, 2'b01, 3'd2, 1'b1);
        wait_drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
